// File: rtl/div_ratio_ctrl.sv
// Divider ratio controller: gates the downstream divider on a falling edge of
// its output (or after a bounded wait), loads the new ratio, then re-enables it.
module div_ratio_ctrl #(
   parameter int INT_WIDTH = 8,
   parameter int RST_RATIO = 1
) (
   input  logic                 i_ref_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req_valid,
   input  logic [INT_WIDTH-1:0] i_req_ratio,
   output logic                 o_req_ready,
   input  logic                 i_div_clk,
   output logic [INT_WIDTH-1:0] o_div_ratio,
   output logic                 o_clk_en,
   output logic                 o_update,
   output logic                 o_timeout
);

   localparam int                   CW     = INT_WIDTH + 1;
   localparam logic [INT_WIDTH-1:0] RST_R  = INT_WIDTH'(RST_RATIO);
   localparam logic                 RST_EN = (RST_RATIO >= 2);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_EDGE,
      GATE,
      RESUME
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [INT_WIDTH-1:0] pend_q, pend_d;
   logic [INT_WIDTH-1:0] ratio_q, ratio_d;
   logic                 en_q, en_d;
   logic                 upd_q, upd_d;
   logic                 to_q, to_d;
   logic                 prev_q;
   logic                 accept;
   logic                 fall;
   logic                 cnt_max;

   assign accept  = i_req_valid && (state_q == IDLE);
   assign fall    = prev_q && !i_div_clk;
   assign cnt_max = &cnt_q;

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = en_q ? WAIT_EDGE : GATE;
         end
         WAIT_EDGE: begin
            if (fall || cnt_max) state_d = GATE;
         end
         GATE:    state_d = RESUME;
         RESUME:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Edge takes priority over the wait limit, so a coincident timeout is silent.
   always_comb begin
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      ratio_d = ratio_q;
      en_d    = en_q;
      upd_d   = 1'b0;
      to_d    = 1'b0;
      if (state_q == WAIT_EDGE) cnt_d = cnt_q + CW'(1);
      if (accept) begin
         cnt_d  = '0;
         pend_d = i_req_ratio;
      end
      if (state_d == GATE) en_d = 1'b0;
      if (state_q == GATE) begin
         ratio_d = pend_q;
         en_d    = |pend_q[INT_WIDTH-1:1];
         upd_d   = 1'b1;
      end
      to_d = (state_q == WAIT_EDGE) && !fall && cnt_max;
   end

   always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q   <= '0;
         pend_q  <= RST_R;
         ratio_q <= RST_R;
         en_q    <= RST_EN;
         upd_q   <= 1'b0;
         to_q    <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         ratio_q <= ratio_d;
         en_q    <= en_d;
         upd_q   <= upd_d;
         to_q    <= to_d;
         prev_q  <= i_div_clk;
      end
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_div_ratio = ratio_q;
   assign o_clk_en    = en_q;
   assign o_update    = upd_q;
   assign o_timeout   = to_q;

endmodule
